ivl_uvm_ovl_clk_mon: RTL and testbench
======================================

IVL_UVM_OVL_CLK_MON -- requirements
Module: ivl_uvm_ovl_clk_mon

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all cycle counters.
REQ-002 SHALL have parameter MIN_PERIOD, default 8, minimum legal mon_clk period in clk cycles.
REQ-003 SHALL have parameter MAX_PERIOD, default 12, maximum legal mon_clk period in clk cycles.
REQ-004 SHALL have parameter TIMEOUT, default 64, clk cycles without a mon_clk edge before stuck is declared.
REQ-005 SHALL have parameters DUTY_MIN_PCT, default 40, and DUTY_MAX_PCT, default 60, legal high-phase percentage bounds.
REQ-006 SHALL have port clk  input  1  reference sampling clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port mon_en  input  1  monitor enable, synchronous to clk.
REQ-009 SHALL have port mon_clk  input  1  clock under test, asynchronous to clk.
REQ-010 SHALL have port meas_valid  output  1  one-cycle pulse, new measurement on hi_cnt/lo_cnt/period_cnt.
REQ-011 SHALL have ports hi_cnt, lo_cnt  output  CNT_W  high/low phase lengths in clk cycles.
REQ-012 SHALL have port period_cnt  output  CNT_W+1  hi_cnt + lo_cnt.
REQ-013 SHALL have port per_err  output  1  pulse with meas_valid when period out of range.
REQ-014 SHALL have port duty_err  output  1  pulse with meas_valid when duty out of range.
REQ-015 SHALL have port stuck_err  output  1  level, mon_clk stopped.

Function
REQ-016 SHALL synchronise mon_clk through two flops, then one delay flop; rise = sync & ~dly, fall = ~sync & dly.
REQ-017 SHALL implement states IDLE, MEAS_HIGH, MEAS_LOW, STUCK.
REQ-018 IDLE -> MEAS_HIGH on first rise while mon_en=1; the first partial phase SHALL never be reported.
REQ-019 MEAS_HIGH -> MEAS_LOW on fall, latching hi_q <= cnt; MEAS_LOW -> MEAS_HIGH on rise, completing a measurement.
REQ-020 cnt SHALL load 1 on every edge cycle, else increment by 1, saturating at all-ones.
REQ-021 On completing rise: hi_cnt<=hi_q, lo_cnt<=cnt, period_cnt<=hi_q+cnt (zero-extended), meas_valid=1 for exactly the next clk cycle.
REQ-022 per_err SHALL equal (period < MIN_PERIOD) | (period > MAX_PERIOD), registered alongside meas_valid; 0 otherwise.
REQ-023 In IDLE, MEAS_HIGH or MEAS_LOW, cnt reaching TIMEOUT with no edge SHALL enter STUCK and set stuck_err=1.
REQ-024 STUCK: stuck_err held; on rise -> MEAS_HIGH, on fall -> MEAS_LOW with hi_q invalid so the next rise produces no meas_valid; stuck_err clears on that edge.
REQ-025 Edge and timeout in the same cycle: edge wins, no STUCK entry.
REQ-026 mon_en=0 SHALL force IDLE next cycle, cnt=0, stuck_err=0, no meas_valid; latched hi_cnt/lo_cnt/period_cnt retain values.
REQ-027 Measurement latency: meas_valid SHALL assert 4 clk cycles after the mon_clk rising edge crosses a clk edge (2 sync + 1 detect + 1 output).

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE; meas_valid, per_err, duty_err, stuck_err, hi_cnt, lo_cnt, period_cnt, cnt, hi_q and all sync flops to 0.
REQ-029 Reset mid-measurement SHALL discard the partial measurement; post-reset behaviour identical to power-up.

Configuration
REQ-030 Macro IVL_UVM_OVL_CLK_MON_DUTY_CHK_EN defined: duty_err = (hi_q*100 < DUTY_MIN_PCT*period) | (hi_q*100 > DUTY_MAX_PCT*period), widths sized to avoid overflow, registered with meas_valid.
REQ-031 Macro undefined: duty_err tied to 0, no multiplier/comparator logic present; all other behaviour unchanged.

Verification
REQ-032 clk 100 MHz, mon_clk 10 MHz 50% -> from second rise onward meas_valid every 10 cycles, hi_cnt=5, lo_cnt=5, period_cnt=10, no errors.
REQ-033 mon_clk 5 MHz (period 20) -> period_cnt=20, per_err=1 with each meas_valid.
REQ-034 mon_clk 10 MHz 20% duty, macro defined -> hi_cnt=2, lo_cnt=8, duty_err=1; macro undefined -> duty_err=0.
REQ-035 mon_clk held high 100 clk cycles -> stuck_err=1 at cnt=64; next fall clears it, first following rise yields no meas_valid, second rise valid.
REQ-036 rst_n low for 3 cycles mid-MEAS_LOW -> all outputs 0 immediately; first meas_valid only after a full high+low phase post-reset.
REQ-037 mon_en dropped mid-MEAS_HIGH -> no meas_valid; re-enable -> first report after one complete period.

Source files
------------

// File: rtl/ivl_uvm_ovl_clk_mon.sv
// Clock monitor: measures high/low phase lengths of mon_clk in clk cycles and flags period, duty and stuck faults.
// Duty checking is built only when IVL_UVM_OVL_CLK_MON_DUTY_CHK_EN is defined; otherwise duty_err is tied low.
module ivl_uvm_ovl_clk_mon #(
   parameter int CNT_W        = 16,
   parameter int MIN_PERIOD   = 8,
   parameter int MAX_PERIOD   = 12,
   parameter int TIMEOUT      = 64,
   parameter int DUTY_MIN_PCT = 40,
   parameter int DUTY_MAX_PCT = 60
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mon_en,
   input  logic             mon_clk,
   output logic             meas_valid,
   output logic [CNT_W-1:0] hi_cnt,
   output logic [CNT_W-1:0] lo_cnt,
   output logic [CNT_W:0]   period_cnt,
   output logic             per_err,
   output logic             duty_err,
   output logic             stuck_err
);

   typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW, STUCK} state_t;

   localparam logic [31:0] TIMEOUT_W = TIMEOUT;
   localparam logic [31:0] MIN_W     = MIN_PERIOD;
   localparam logic [31:0] MAX_W     = MAX_PERIOD;

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q, dly_q, rise_q, fall_q;
   logic             rise_d, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic             hi_vld_q, hi_vld_d;
   logic             meas_valid_q, meas_valid_d;
   logic             per_err_q, per_err_d;
   logic             stuck_q, stuck_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
   logic [CNT_W:0]   period_cnt_q, period_cnt_d, sum;
   logic             edge_seen, timeout_hit;

   // Edge pulses are registered so the detect stage is its own pipeline step.
   assign rise_d = sync2_q & ~dly_q;
   assign fall_d = ~sync2_q & dly_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dly_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= mon_clk;
         sync2_q <= sync1_q;
         dly_q   <= sync2_q;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

`ifdef IVL_UVM_OVL_CLK_MON_DUTY_CHK_EN
   localparam int DW = CNT_W + 8;
   logic          duty_err_q, duty_err_d, duty_bad;
   logic [DW-1:0] hi_x100, dmin_lim, dmax_lim;

   always_comb begin
      hi_x100  = DW'(hi_q) * DW'(100);
      dmin_lim = DW'(sum) * DW'(DUTY_MIN_PCT);
      dmax_lim = DW'(sum) * DW'(DUTY_MAX_PCT);
      duty_bad = (hi_x100 < dmin_lim) | (hi_x100 > dmax_lim);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) duty_err_q <= 1'b0;
      else        duty_err_q <= duty_err_d;
   end

   assign duty_err = duty_err_q;
`else
   assign duty_err = 1'b0;
`endif

   always_comb begin
      edge_seen   = rise_q | fall_q;
      cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      timeout_hit = ~edge_seen & (32'(cnt_inc) >= TIMEOUT_W);
      sum         = {1'b0, hi_q} + {1'b0, cnt_q};

      state_d      = state_q;
      cnt_d        = edge_seen ? {{(CNT_W-1){1'b0}}, 1'b1} : cnt_inc;
      hi_d         = hi_q;
      hi_vld_d     = hi_vld_q;
      meas_valid_d = 1'b0;
      per_err_d    = 1'b0;
      stuck_d      = stuck_q;
      hi_cnt_d     = hi_cnt_q;
      lo_cnt_d     = lo_cnt_q;
      period_cnt_d = period_cnt_q;
`ifdef IVL_UVM_OVL_CLK_MON_DUTY_CHK_EN
      duty_err_d   = 1'b0;
`endif

      if (!mon_en) begin
         state_d = IDLE;
         cnt_d   = '0;
         stuck_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise_q) begin
                  state_d = MEAS_HIGH;
               end else if (timeout_hit) begin
                  state_d = STUCK;
                  stuck_d = 1'b1;
               end
            end
            MEAS_HIGH: begin
               if (fall_q) begin
                  state_d  = MEAS_LOW;
                  hi_d     = cnt_q;
                  hi_vld_d = 1'b1;
               end else if (timeout_hit) begin
                  state_d = STUCK;
                  stuck_d = 1'b1;
               end
            end
            MEAS_LOW: begin
               if (rise_q) begin
                  state_d = MEAS_HIGH;
                  // A low phase entered from STUCK has no matching high phase to pair with.
                  if (hi_vld_q) begin
                     meas_valid_d = 1'b1;
                     hi_cnt_d     = hi_q;
                     lo_cnt_d     = cnt_q;
                     period_cnt_d = sum;
                     per_err_d    = (32'(sum) < MIN_W) | (32'(sum) > MAX_W);
`ifdef IVL_UVM_OVL_CLK_MON_DUTY_CHK_EN
                     duty_err_d   = duty_bad;
`endif
                  end
               end else if (timeout_hit) begin
                  state_d = STUCK;
                  stuck_d = 1'b1;
               end
            end
            STUCK: begin
               if (rise_q) begin
                  state_d = MEAS_HIGH;
                  stuck_d = 1'b0;
               end else if (fall_q) begin
                  state_d  = MEAS_LOW;
                  hi_vld_d = 1'b0;
                  stuck_d  = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         hi_q         <= '0;
         hi_vld_q     <= 1'b0;
         meas_valid_q <= 1'b0;
         per_err_q    <= 1'b0;
         stuck_q      <= 1'b0;
         hi_cnt_q     <= '0;
         lo_cnt_q     <= '0;
         period_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         hi_vld_q     <= hi_vld_d;
         meas_valid_q <= meas_valid_d;
         per_err_q    <= per_err_d;
         stuck_q      <= stuck_d;
         hi_cnt_q     <= hi_cnt_d;
         lo_cnt_q     <= lo_cnt_d;
         period_cnt_q <= period_cnt_d;
      end
   end

   assign meas_valid = meas_valid_q;
   assign hi_cnt     = hi_cnt_q;
   assign lo_cnt     = lo_cnt_q;
   assign period_cnt = period_cnt_q;
   assign per_err    = per_err_q;
   assign stuck_err  = stuck_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_clk_mon.sv
// Scoreboard bench for ivl_uvm_ovl_clk_mon: directed mon_clk waveforms push expected reports,
// a negedge monitor pops and compares on every meas_valid.
module tb_ivl_uvm_ovl_clk_mon;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mon_en = 1'b0;
   logic        mon_clk = 1'b0;
   logic        meas_valid;
   logic [15:0] hi_cnt, lo_cnt;
   logic [16:0] period_cnt;
   logic        per_err, duty_err, stuck_err;

   int checks = 0;
   int errors = 0;
   int n_meas = 0;

   typedef struct packed {
      logic [15:0] hi;
      logic [15:0] lo;
      logic [16:0] per;
      logic        perr;
      logic        derr;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   ivl_uvm_ovl_clk_mon #(
      .CNT_W(16), .MIN_PERIOD(8), .MAX_PERIOD(12), .TIMEOUT(64),
      .DUTY_MIN_PCT(40), .DUTY_MAX_PCT(60)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .mon_clk(mon_clk),
      .meas_valid(meas_valid), .hi_cnt(hi_cnt), .lo_cnt(lo_cnt),
      .period_cnt(period_cnt), .per_err(per_err), .duty_err(duty_err),
      .stuck_err(stuck_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Drive mon_clk to v for n clk cycles; callers are always aligned to a clk negedge.
   task automatic mon_phase(input logic v, input int n);
      mon_clk = v;
      repeat (n) @(negedge clk);
   endtask

   // One full mon_clk period whose report is expected at the next rise.
   task automatic period(input int h, input int l, input logic perr, input logic derr_en);
      exp_t e;
      e.hi   = 16'(h);
      e.lo   = 16'(l);
      e.per  = 17'(h + l);
      e.perr = perr;
`ifdef IVL_UVM_OVL_CLK_MON_DUTY_CHK_EN
      e.derr = derr_en;
`else
      e.derr = 1'b0;
`endif
      exp_q.push_back(e);
      mon_phase(1'b1, h);
      mon_phase(1'b0, l);
   endtask

   // Final rise completes the last pushed period, then disable and re-arm from IDLE.
   task automatic finish_burst();
      mon_phase(1'b1, 8);
      mon_en  = 1'b0;
      mon_clk = 1'b0;
      repeat (6) @(negedge clk);
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && meas_valid) begin
         n_meas++;
         $display("meas %0d: hi=%0d lo=%0d period=%0d per_err=%0d duty_err=%0d",
                  n_meas, hi_cnt, lo_cnt, period_cnt, per_err, duty_err);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_meas: got meas_valid=1 hi=%0d lo=%0d, expected no report",
                     hi_cnt, lo_cnt);
         end else begin
            e = exp_q.pop_front();
            check("hi_cnt", 32'(hi_cnt), 32'(e.hi));
            check("lo_cnt", 32'(lo_cnt), 32'(e.lo));
            check("period_cnt", 32'(period_cnt), 32'(e.per));
            check("per_err", 32'(per_err), 32'(e.perr));
            check("duty_err", 32'(duty_err), 32'(e.derr));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_meas_valid", 32'(meas_valid), 32'd0);
      check("rst_hi_cnt", 32'(hi_cnt), 32'd0);
      check("rst_period_cnt", 32'(period_cnt), 32'd0);
      check("rst_stuck_err", 32'(stuck_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      repeat (3) @(negedge clk);

      // 10 MHz, 50 % duty
      repeat (3) period(5, 5, 1'b0, 1'b0);
      finish_burst();
      // 5 MHz: period too long
      repeat (2) period(10, 10, 1'b1, 1'b0);
      finish_burst();
      // 20 % duty
      repeat (2) period(2, 8, 1'b0, 1'b1);
      finish_burst();
      // period and duty boundaries
      period(4, 4, 1'b0, 1'b0);
      period(3, 4, 1'b1, 1'b0);
      period(6, 6, 1'b0, 1'b0);
      period(6, 7, 1'b1, 1'b0);
      period(4, 6, 1'b0, 1'b0);
      period(6, 4, 1'b0, 1'b0);
      period(3, 7, 1'b0, 1'b1);
      period(7, 3, 1'b0, 1'b1);
      finish_burst();

      // stuck high, recovery skips the orphan low phase
      mon_phase(1'b1, 100);
      check("stuck_set", 32'(stuck_err), 32'd1);
      mon_phase(1'b0, 5);
      check("stuck_clear", 32'(stuck_err), 32'd0);
      period(5, 5, 1'b0, 1'b0);
      finish_burst();

      // reset in the middle of a low phase
      mon_phase(1'b1, 5);
      mon_phase(1'b0, 2);
      rst_n = 1'b0;
      #1;
      check("arst_hi_cnt", 32'(hi_cnt), 32'd0);
      check("arst_lo_cnt", 32'(lo_cnt), 32'd0);
      check("arst_period_cnt", 32'(period_cnt), 32'd0);
      check("arst_meas_valid", 32'(meas_valid), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mon_phase(1'b0, 4);
      period(4, 6, 1'b0, 1'b0);
      finish_burst();

      // mon_en dropped mid high phase; outputs retain last report
      mon_phase(1'b1, 6);
      mon_en = 1'b0;
      mon_phase(1'b1, 2);
      mon_phase(1'b0, 5);
      mon_phase(1'b1, 5);
      mon_phase(1'b0, 6);
      check("hold_hi_cnt", 32'(hi_cnt), 32'd4);
      check("hold_lo_cnt", 32'(lo_cnt), 32'd6);
      check("hold_period_cnt", 32'(period_cnt), 32'd10);
      mon_en = 1'b1;
      mon_phase(1'b0, 3);
      period(6, 5, 1'b0, 1'b0);
      finish_burst();

      repeat (10) @(negedge clk);
      check("pending_reports", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
